calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the 28-bit signed add datapath of the FPGA calculator.
- Builds operands from keypad digit strokes.
- Issues a one-cycle launch to the adder and waits for its result and overflow flag.
- Drives the display value and error flag.
- Performs subtraction by handing the adder a negated second operand, so the datapath only ever adds.

Parameters:
- W, 28, operand/result width (two's complement, sign included)
- MAX_DIGITS, 8, maximum decimal digits accepted per operand
- TIMEOUT, 15, cycles allowed in WAIT before error (used only with CALC_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle strobe, one key per strobe
- key_code  in  4  0-9 digit, A plus, B minus, C equals, D clear, E sign toggle, F ignored
- op_a  out  W  adder operand 1 (registered)
- op_b  out  W  adder operand 2, already negated for minus (registered)
- op_valid  out  1  adder launch strobe
- res  in  W  adder sum
- res_ovf  in  1  adder overflow (|sum| > 99_999_999)
- res_valid  in  1  adder result strobe, one cycle after op_valid
- disp_val  out  W  value to display (signed)
- disp_err  out  1  error indicator
- busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset values: state ENTER_A; acc, neg, digit count, op_a, op_b, disp_val all 0; op_valid, disp_err, busy 0.
- Digit key in ENTER_A or ENTER_B:
  - If count < MAX_DIGITS: acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d, and count++.
  - Otherwise the key is ignored.
  - disp_val <= neg ? -acc : acc, updated the cycle after key_valid.
- Sign key (E) in ENTER_A/ENTER_B toggles neg and updates the display. Leading zeros are counted as digits.
- ENTER_A, on plus/minus: op_a <= signed acc; store op; clear acc/neg/count; go to ENTER_B. Equals is ignored.
- ENTER_B, on equals: op_b <= (op==minus) ? -(signed acc) : signed acc; go to ISSUE. Plus/minus are ignored.
- ISSUE: op_valid=1 for exactly one cycle; next state WAIT.
- WAIT: res_valid is sampled only in this state.
  - On res_valid with res_ovf=1: disp_err <= 1, disp_val <= all ones, go to ERROR.
  - On res_valid with res_ovf=0: disp_val <= res, go to SHOW.
  - A res_valid arriving outside WAIT is ignored.
- SHOW:
  - Digit key: start a new operand (acc=d, count=1), go to ENTER_A.
  - Plus/minus: op_a <= disp_val, store op, go to ENTER_B (chaining).
  - Equals and sign keys are ignored.
- ERROR: all keys ignored except clear.
- Clear (D) in any state, including ISSUE/WAIT:
  - Next state ENTER_A; acc/neg/count/op_a/op_b/disp_val reset to 0; disp_err=0; op_valid=0.
  - An in-flight adder result is discarded.
- Keys other than clear are ignored in ISSUE and WAIT.
- Negation of an operand with value 0 yields 0; -0 is never displayed.
- Latency: equals key -> op_valid is 2 cycles (ENTER_B register, then ISSUE). res_valid -> disp_val is 1 cycle.

Optional Feature:
- CALC_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT without res_valid: disp_err=1, disp_val=all ones, go to ERROR.
  - A res_valid on the same cycle as expiry wins.
- CALC_TIMEOUT_EN undefined: no counter; WAIT persists until res_valid or clear.

Decomposition:
- Package calc_pkg holds:
  - key code localparams
  - state encoding (ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERROR)
  - W default
  - MAX_VAL = 99_999_999
  - ERR_PATTERN = all ones
- One natural sub-module: calc_operand_entry, holding acc, neg, digit count, multiply-by-10, sign toggle and clear. It outputs the signed operand.

Test Plan:
- Keys 1,2,+,3,4,= -> op_valid pulse with op_a=12, op_b=34; model res_valid next cycle with res=46 -> disp_val=46, busy=0.
- Keys 5,-,9,= -> op_b=-9; res=-4 -> disp_val=-4 (0xFFFFFFC).
- Keys 9 x8, then 9 (9th digit ignored), +, 1, = -> op_a=99_999_999, op_b=1; res_ovf=1 -> disp_err=1, disp_val=all ones. Digit/plus/equals ignored until D, after which everything is 0.
- After result 46 in SHOW: keys +,4,= -> op_a=46, op_b=4 (chaining). Key 7 in SHOW -> ENTER_A with disp_val=7.
- Clear asserted the cycle after op_valid, res_valid following -> state ENTER_A, disp_val stays 0.
- With CALC_TIMEOUT_EN: no res_valid for 15 WAIT cycles -> ERROR, disp_err=1. Without it: still busy after 100 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller.
//   - default datapath width, digit limit and WAIT timeout
//   - key code values, FSM state encoding, error display pattern
package calc_pkg;

  localparam int unsigned CALC_W          = 28;
  localparam int unsigned CALC_MAX_DIGITS = 8;
  localparam int unsigned CALC_TIMEOUT    = 15;

  // Largest magnitude the display can show
  localparam logic [CALC_W-1:0] MAX_VAL     = CALC_W'(99_999_999);
  // Value shown alongside the error indicator
  localparam logic [CALC_W-1:0] ERR_PATTERN = '1;

  localparam logic [3:0] KEY_PLUS   = 4'hA;
  localparam logic [3:0] KEY_MINUS  = 4'hB;
  localparam logic [3:0] KEY_EQUALS = 4'hC;
  localparam logic [3:0] KEY_CLEAR  = 4'hD;
  localparam logic [3:0] KEY_SIGN   = 4'hE;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ISSUE,
    WAIT,
    SHOW,
    ERROR
  } calc_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_operand_entry.sv
// Operand builder: accumulates decimal digits, tracks sign, clears on request.
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             zero accumulator, sign and digit count
//   load            start a fresh operand equal to 'digit' (count = 1)
//   digit_en        append 'digit' if fewer than MAX_DIGITS digits held
//   sign_en         toggle the sign
//   digit           decimal digit 0-9
//   value_c         current signed operand
//   val_digit_c     operand as it would be after appending 'digit'
//   val_sign_c      operand as it would be after a sign toggle
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned W          = CALC_W,
  parameter int unsigned MAX_DIGITS = CALC_MAX_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         digit_en,
  input  logic         sign_en,
  input  logic [3:0]   digit,
  output logic [W-1:0] value_c,
  output logic [W-1:0] val_digit_c,
  output logic [W-1:0] val_sign_c
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic [W-1:0]     acc;
  logic [W-1:0]     acc_dig;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic             room;

  // Two's complement negate; a zero magnitude stays zero
  function automatic logic [W-1:0] apply_sign(input logic n, input logic [W-1:0] m);
    return n ? (~m + W'(1)) : m;
  endfunction

  // acc*10 + d via shifts; a full operand is left untouched
  assign room    = (cnt < CNT_W'(MAX_DIGITS));
  assign acc_dig = room ? ((acc << 3) + (acc << 1) + W'(digit)) : acc;

  assign value_c     = apply_sign(neg, acc);
  assign val_digit_c = apply_sign(neg, acc_dig);
  assign val_sign_c  = apply_sign(~neg, acc);

  // Accumulator, sign and digit count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      neg <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      neg <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      acc <= W'(digit);
      neg <= 1'b0;
      cnt <= CNT_W'(1);
    end else if (digit_en && room) begin
      acc <= acc_dig;
      cnt <= cnt + CNT_W'(1);
    end else if (sign_en) begin
      neg <= ~neg;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the calculator's signed add datapath.
// Builds two operands from keypad strokes, launches the adder for one cycle,
// waits for the sum and drives the display. Minus is done by negating op_b.
// Ports:
//   clk, rst            clock, async active-high reset
//   key_valid/key_code  keypad strobe and code (0-9, A +, B -, C =, D clr, E sign)
//   op_a, op_b          adder operands (op_b already negated for minus)
//   op_valid            one-cycle adder launch
//   res/res_ovf         adder sum and overflow, qualified by res_valid
//   disp_val/disp_err   display value and error indicator
//   busy                high while a sum is being issued or awaited
// Build option: define CALC_TIMEOUT_EN to abandon WAIT after TIMEOUT cycles.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned W          = CALC_W,
  parameter int unsigned MAX_DIGITS = CALC_MAX_DIGITS
`ifdef CALC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = CALC_TIMEOUT
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_valid,
  input  logic [W-1:0] res,
  input  logic         res_ovf,
  input  logic         res_valid,
  output logic [W-1:0] disp_val,
  output logic         disp_err,
  output logic         busy
);

  calc_state_e  state, state_nxt;
  logic         op_sub, op_sub_nxt;
  logic [W-1:0] op_a_nxt, op_b_nxt, disp_val_nxt;
  logic         disp_err_nxt, op_valid_nxt, busy_nxt;

  logic ent_clr_c, ent_load_c, ent_digit_c, ent_sign_c;
  logic [W-1:0] ent_value_c, ent_val_digit_c, ent_val_sign_c;

  logic key_digit, key_pm, key_minus, key_equals, key_clear, key_sign;

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
`endif

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_minus  = key_valid && (key_code == KEY_MINUS);
  assign key_pm     = key_valid && ((key_code == KEY_PLUS) || (key_code == KEY_MINUS));
  assign key_equals = key_valid && (key_code == KEY_EQUALS);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);
  assign key_sign   = key_valid && (key_code == KEY_SIGN);

  calc_operand_entry #(
    .W          (W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_entry (
    .clk         (clk),
    .rst         (rst),
    .clr         (ent_clr_c),
    .load        (ent_load_c),
    .digit_en    (ent_digit_c),
    .sign_en     (ent_sign_c),
    .digit       (key_code),
    .value_c     (ent_value_c),
    .val_digit_c (ent_val_digit_c),
    .val_sign_c  (ent_val_sign_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENTER_A;
    else     state <= state_nxt;
  end

  // Next state, entry controls and next values of registered outputs
  always_comb begin
    state_nxt    = state;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_sub_nxt   = op_sub;
    disp_val_nxt = disp_val;
    disp_err_nxt = disp_err;
    op_valid_nxt = 1'b0;
    ent_clr_c    = 1'b0;
    ent_load_c   = 1'b0;
    ent_digit_c  = 1'b0;
    ent_sign_c   = 1'b0;
`ifdef CALC_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
`endif

    if (key_clear) begin
      // Clear beats everything, including a result arriving this cycle
      state_nxt    = ENTER_A;
      op_a_nxt     = '0;
      op_b_nxt     = '0;
      op_sub_nxt   = 1'b0;
      disp_val_nxt = '0;
      disp_err_nxt = 1'b0;
      ent_clr_c    = 1'b1;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (key_digit) begin
            ent_digit_c  = 1'b1;
            disp_val_nxt = ent_val_digit_c;
          end else if (key_sign) begin
            ent_sign_c   = 1'b1;
            disp_val_nxt = ent_val_sign_c;
          end else if ((state == ENTER_A) && key_pm) begin
            op_a_nxt   = ent_value_c;
            op_sub_nxt = key_minus;
            ent_clr_c  = 1'b1;
            state_nxt  = ENTER_B;
          end else if ((state == ENTER_B) && key_equals) begin
            op_b_nxt  = op_sub ? (~ent_value_c + W'(1)) : ent_value_c;
            ent_clr_c = 1'b1;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          op_valid_nxt = 1'b1;
          state_nxt    = WAIT;
`ifdef CALC_TIMEOUT_EN
          to_cnt_nxt   = '0;
`endif
        end
        WAIT: begin
          if (res_valid) begin
            if (res_ovf) begin
              disp_err_nxt = 1'b1;
              disp_val_nxt = {W{1'b1}};
              state_nxt    = ERROR;
            end else begin
              disp_val_nxt = res;
              state_nxt    = SHOW;
            end
          end
`ifdef CALC_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            disp_err_nxt = 1'b1;
            disp_val_nxt = {W{1'b1}};
            state_nxt    = ERROR;
          end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
          end
`endif
        end
        SHOW: begin
          if (key_digit) begin
            ent_load_c   = 1'b1;
            disp_val_nxt = W'(key_code);
            state_nxt    = ENTER_A;
          end else if (key_pm) begin
            // Chain: the shown result becomes the first operand
            op_a_nxt   = disp_val;
            op_sub_nxt = key_minus;
            ent_clr_c  = 1'b1;
            state_nxt  = ENTER_B;
          end
        end
        ERROR: begin
          state_nxt = ERROR;
        end
        default: begin
          state_nxt = ENTER_A;
        end
      endcase
    end

    busy_nxt = (state_nxt == ISSUE) || (state_nxt == WAIT);
  end

  // Registered outputs and operator memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      op_valid <= 1'b0;
      disp_val <= '0;
      disp_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      op_a     <= op_a_nxt;
      op_b     <= op_b_nxt;
      op_sub   <= op_sub_nxt;
      op_valid <= op_valid_nxt;
      disp_val <= disp_val_nxt;
      disp_err <= disp_err_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // WAIT cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl with a one-cycle adder model.
module tb_calc_seq_ctrl;

  localparam int unsigned W = 28;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'hF;
  logic [W-1:0] op_a, op_b, res, disp_val;
  logic         op_valid, res_ovf, res_valid, disp_err, busy;

  logic adder_en = 1'b1;
  logic inject   = 1'b0;

  int total = 0;
  int bad   = 0;

  calc_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .res       (res),
    .res_ovf   (res_ovf),
    .res_valid (res_valid),
    .disp_val  (disp_val),
    .disp_err  (disp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Adder: answers one cycle after the launch strobe
  always @(posedge clk) begin : adder_model
    logic signed [W-1:0] s;
    logic [W-1:0]        mag;
    s   = $signed(op_a) + $signed(op_b);
    mag = s[W-1] ? W'(-s) : W'(s);
    res       <= W'(s);
    res_ovf   <= (mag > W'(99_999_999));
    res_valid <= (adder_en && op_valid) || inject;
  end

  // Key held for one clock; called and returns 1 time unit after a rising edge
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  // Press equals, sample the launch cycle, then let the result land
  task automatic launch(output logic ov, output logic bz, output logic [W-1:0] a, output logic [W-1:0] b);
    press(4'hC);
    @(posedge clk); #1;
    ov = op_valid; bz = busy; a = op_a; b = op_b;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({op_a, op_b, disp_val} !== '0) begin bad++; $display("FAIL reset_vals got=%0h/%0h/%0h want=0", op_a, op_b, disp_val); end
    total++; if ({op_valid, disp_err, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {op_valid, disp_err, busy}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic ov, bz; logic [W-1:0] a, b;
    press(4'd1); press(4'd2);
    total++; if (disp_val !== 28'd12) begin bad++; $display("FAIL add_disp12 got=%0d want=12", disp_val); end
    press(4'hA); press(4'd3); press(4'd4);
    total++; if (disp_val !== 28'd34) begin bad++; $display("FAIL add_disp34 got=%0d want=34", disp_val); end
    press(4'hC);
    total++; if (op_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL add_issue got=ov%b bz%b want=ov0 bz1", op_valid, busy); end
    @(posedge clk); #1;
    ov = op_valid; a = op_a; b = op_b;
    total++; if (ov !== 1'b1 || a !== 28'd12 || b !== 28'd34) begin bad++; $display("FAIL add_launch got=ov%b a%0d b%0d want=ov1 a12 b34", ov, a, b); end
    @(posedge clk); #1;
    total++; if (op_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL add_pulse got=ov%b bz%b want=ov0 bz1", op_valid, busy); end
    @(posedge clk); #1;
    total++; if (disp_val !== 28'd46 || busy !== 1'b0 || disp_err !== 1'b0) begin bad++; $display("FAIL add_result got=%0d bz%b want=46 bz0", disp_val, busy); end
  endtask

  task automatic test_chain();
    logic ov, bz; logic [W-1:0] a, b;
    press(4'hA); press(4'd4);
    launch(ov, bz, a, b);
    total++; if (ov !== 1'b1 || a !== 28'd46 || b !== 28'd4) begin bad++; $display("FAIL chain_ops got=ov%b a%0d b%0d want=ov1 a46 b4", ov, a, b); end
    total++; if (disp_val !== 28'd50) begin bad++; $display("FAIL chain_result got=%0d want=50", disp_val); end
    press(4'hC); press(4'hE);
    total++; if (disp_val !== 28'd50 || busy !== 1'b0) begin bad++; $display("FAIL show_ignore got=%0d bz%b want=50 bz0", disp_val, busy); end
    press(4'd7);
    total++; if (disp_val !== 28'd7) begin bad++; $display("FAIL show_digit got=%0d want=7", disp_val); end
    press(4'd1);
    total++; if (disp_val !== 28'd71) begin bad++; $display("FAIL show_newop got=%0d want=71", disp_val); end
  endtask

  task automatic test_sub();
    logic ov, bz; logic [W-1:0] a, b;
    press(4'hD); press(4'd5); press(4'hB); press(4'd9);
    launch(ov, bz, a, b);
    total++; if (ov !== 1'b1 || bz !== 1'b1 || a !== 28'd5 || b !== 28'hFFFFFF7) begin bad++; $display("FAIL sub_ops got=ov%b a%0h b%0h want=ov1 a5 bFFFFFF7", ov, a, b); end
    total++; if (disp_val !== 28'hFFFFFFC) begin bad++; $display("FAIL sub_result got=%0h want=FFFFFFC", disp_val); end
  endtask

  task automatic test_sign();
    logic ov, bz; logic [W-1:0] a, b;
    press(4'hD); press(4'hE);
    total++; if (disp_val !== 28'd0) begin bad++; $display("FAIL sign_zero got=%0h want=0", disp_val); end
    press(4'd5);
    total++; if (disp_val !== 28'hFFFFFFB) begin bad++; $display("FAIL sign_neg5 got=%0h want=FFFFFFB", disp_val); end
    press(4'hA); press(4'd2); press(4'hE);
    total++; if (disp_val !== 28'hFFFFFFE) begin bad++; $display("FAIL sign_neg2 got=%0h want=FFFFFFE", disp_val); end
    launch(ov, bz, a, b);
    total++; if (a !== 28'hFFFFFFB || b !== 28'hFFFFFFE || disp_val !== 28'hFFFFFF9) begin bad++; $display("FAIL sign_sum got=a%0h b%0h d%0h want=aFFFFFFB bFFFFFFE dFFFFFF9", a, b, disp_val); end
    press(4'hD); press(4'd1); press(4'hB); press(4'd0);
    launch(ov, bz, a, b);
    total++; if (b !== 28'd0 || disp_val !== 28'd1) begin bad++; $display("FAIL minus_zero got=b%0h d%0h want=b0 d1", b, disp_val); end
  endtask

  task automatic test_overflow();
    logic ov, bz; logic [W-1:0] a, b;
    press(4'hD);
    repeat (9) press(4'd9);
    total++; if (disp_val !== 28'd99_999_999) begin bad++; $display("FAIL max_digits got=%0d want=99999999", disp_val); end
    press(4'hA); press(4'd1);
    launch(ov, bz, a, b);
    total++; if (a !== 28'd99_999_999 || b !== 28'd1) begin bad++; $display("FAIL ovf_ops got=a%0d b%0d want=a99999999 b1", a, b); end
    total++; if (disp_err !== 1'b1 || disp_val !== 28'hFFFFFFF) begin bad++; $display("FAIL ovf_err got=e%b d%0h want=e1 dFFFFFFF", disp_err, disp_val); end
    press(4'd5); press(4'hA); press(4'hC);
    @(posedge clk); #1;
    total++; if (disp_err !== 1'b1 || disp_val !== 28'hFFFFFFF || op_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL err_hold got=e%b d%0h ov%b bz%b want=e1 dFFFFFFF ov0 bz0", disp_err, disp_val, op_valid, busy); end
    press(4'hD);
    total++; if ({op_a, op_b, disp_val} !== '0 || disp_err !== 1'b0) begin bad++; $display("FAIL err_clear got=a%0h b%0h d%0h e%b want=all0", op_a, op_b, disp_val, disp_err); end
  endtask

  task automatic test_clear_inflight();
    press(4'd1); press(4'hA); press(4'd2); press(4'hC);
    @(posedge clk); #1;
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL inflight_launch got=%b want=1", op_valid); end
    press(4'hD);
    total++; if (busy !== 1'b0 || disp_val !== 28'd0) begin bad++; $display("FAIL inflight_clear got=bz%b d%0h want=bz0 d0", busy, disp_val); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (disp_val !== 28'd0 || disp_err !== 1'b0 || busy !== 1'b0 || op_a !== 28'd0) begin bad++; $display("FAIL inflight_discard got=d%0h e%b bz%b a%0h want=all0", disp_val, disp_err, busy, op_a); end
    press(4'd8);
    total++; if (disp_val !== 28'd8) begin bad++; $display("FAIL inflight_enter got=%0d want=8", disp_val); end
  endtask

  task automatic test_stray_result();
    press(4'hD); press(4'd3);
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(posedge clk); #1;
    total++; if (disp_val !== 28'd3 || busy !== 1'b0) begin bad++; $display("FAIL stray_ignored got=d%0d bz%b want=d3 bz0", disp_val, busy); end
    press(4'd4);
    total++; if (disp_val !== 28'd34) begin bad++; $display("FAIL stray_entry got=%0d want=34", disp_val); end
  endtask

  task automatic test_wait_hold();
    press(4'hD); press(4'd1); press(4'hA); press(4'd1);
    adder_en = 1'b0;
    press(4'hC);
`ifdef CALC_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || disp_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=bz%b e%b want=bz1 e0", busy, disp_err); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || disp_err !== 1'b1 || disp_val !== 28'hFFFFFFF) begin bad++; $display("FAIL timeout_err got=bz%b e%b d%0h want=bz0 e1 dFFFFFFF", busy, disp_err, disp_val); end
`else
    repeat (100) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || disp_err !== 1'b0) begin bad++; $display("FAIL wait_hold got=bz%b e%b want=bz1 e0", busy, disp_err); end
    press(4'd5); press(4'hA);
    total++; if (busy !== 1'b1 || disp_val !== 28'd1) begin bad++; $display("FAIL wait_keys got=bz%b d%0d want=bz1 d1", busy, disp_val); end
`endif
    press(4'hD);
    total++; if (busy !== 1'b0 || disp_err !== 1'b0 || disp_val !== 28'd0) begin bad++; $display("FAIL wait_clear got=bz%b e%b d%0h want=bz0 e0 d0", busy, disp_err, disp_val); end
    adder_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_sub();
    test_sign();
    test_overflow();
    test_clear_inflight();
    test_stray_result();
    test_wait_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
